// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with a one-entry skid
// buffer, a FLUSH redirect path and an optional 16-entry bimodal branch
// history table. Define FETCH_BHT_EN to build the BHT; without it the
// prediction outputs are constant (weakly not-taken on valid instructions)
// and the BP_* update inputs are ignored.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] Redirect_Addr,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Instr_Valid_IF,
  output logic        Branch_prediction_IF,
  output logic [1:0]  Branch_predictions_IF,
  input  logic        BP_Update,
  input  logic [31:0] BP_Update_PC,
  input  logic        BP_Update_Taken
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] instr_pc4_q, instr_pc4_d;
  logic        valid_q, valid_d;
  logic [1:0]  preds_q, preds_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [1:0]  skid_preds_q, skid_preds_d;
  logic [1:0]  fetch_pred;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_BHT_EN
  logic [1:0] bht_q [16];
  logic [1:0] bht_d [16];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Read is from the current table, so a same-cycle update is not visible yet
  assign fetch_pred = bht_q[pc_q[5:2]];

  // Saturating counter update for the resolved branch
  always_comb begin
    bht_d = bht_q;
    if (BP_Update) begin
      if (BP_Update_Taken) bht_d[BP_Update_PC[5:2]] = sat_inc(bht_q[BP_Update_PC[5:2]]);
      else                 bht_d[BP_Update_PC[5:2]] = sat_dec(bht_q[BP_Update_PC[5:2]]);
    end
  end

  // BHT storage, every counter starts weakly not-taken
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  logic unused_bp_pc_bits;
  assign unused_bp_pc_bits = ^{BP_Update_PC[31:6], BP_Update_PC[1:0]};
`else
  assign fetch_pred = 2'b01;

  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{BP_Update, BP_Update_PC, BP_Update_Taken};
`endif

  // Next-state logic: FLUSH wins, otherwise fetch/skid/bubble per state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    instr_pc4_d  = instr_pc4_q;
    valid_d      = valid_q;
    preds_d      = preds_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_preds_d = skid_preds_q;

    if (FLUSH) begin
      // Any same-cycle ack is dropped; the skid is abandoned with HOLD
      pc_d        = Redirect_Addr;
      instr_d     = '0;
      instr_pc_d  = '0;
      instr_pc4_d = '0;
      valid_d     = 1'b0;
      preds_d     = '0;
      state_d     = S_REDIR;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          // imem_req_q gates the fetch so the cycle right after reset,
          // where no request was issued, cannot accept a stale ack
          if (imem_req_q && Imem_Ack) begin
            pc_d = pc_plus4;
            if (!STALL || !valid_q) begin
              instr_d     = Imem_Data;
              instr_pc_d  = pc_q;
              instr_pc4_d = pc_plus4;
              valid_d     = 1'b1;
              preds_d     = fetch_pred;
            end else begin
              skid_instr_d = Imem_Data;
              skid_pc_d    = pc_q;
              skid_preds_d = fetch_pred;
              state_d      = S_HOLD;
            end
          end else if (!STALL) begin
            instr_d     = '0;
            instr_pc_d  = '0;
            instr_pc4_d = '0;
            valid_d     = 1'b0;
            preds_d     = '0;
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            instr_d     = skid_instr_q;
            instr_pc_d  = skid_pc_q;
            instr_pc4_d = skid_pc_q + 32'd4;
            valid_d     = 1'b1;
            preds_d     = skid_preds_q;
            state_d     = S_FETCH;
          end
        end
        S_REDIR: begin
          state_d = S_FETCH;
          if (!STALL) begin
            instr_d     = '0;
            instr_pc_d  = '0;
            instr_pc4_d = '0;
            valid_d     = 1'b0;
            preds_d     = '0;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

    imem_req_d = (state_d == S_FETCH);
  end

  // State, PC, skid and output registers; reset clears everything
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_FETCH;
      imem_req_q   <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      instr_pc4_q  <= '0;
      valid_q      <= 1'b0;
      preds_q      <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_preds_q <= '0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      instr_pc4_q  <= instr_pc4_d;
      valid_q      <= valid_d;
      preds_q      <= preds_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_preds_q <= skid_preds_d;
    end
  end

  assign Imem_Req              = imem_req_q;
  assign Imem_Addr             = pc_q;
  assign Instr1_IF             = instr_q;
  assign Instr_PC_IF           = instr_pc_q;
  assign Instr_PC_Plus4_IF     = instr_pc4_q;
  assign Instr_Valid_IF        = valid_q;
  assign Branch_predictions_IF = preds_q;
  assign Branch_prediction_IF  = preds_q[1];

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] Redirect_Addr = '0;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack = 1'b0;
  logic [31:0] Imem_Data;
  logic [31:0] Instr1_IF;
  logic [31:0] Instr_PC_IF;
  logic [31:0] Instr_PC_Plus4_IF;
  logic        Instr_Valid_IF;
  logic        Branch_prediction_IF;
  logic [1:0]  Branch_predictions_IF;
  logic        BP_Update = 1'b0;
  logic [31:0] BP_Update_PC = '0;
  logic        BP_Update_Taken = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .Redirect_Addr(Redirect_Addr),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
    .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF),
    .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF), .Instr_Valid_IF(Instr_Valid_IF),
    .Branch_prediction_IF(Branch_prediction_IF),
    .Branch_predictions_IF(Branch_predictions_IF),
    .BP_Update(BP_Update), .BP_Update_PC(BP_Update_PC),
    .BP_Update_Taken(BP_Update_Taken)
  );

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign Imem_Data = memword(Imem_Addr);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  preds;
    logic        valid;
  } rec_t;

  localparam int M_FETCH = 0, M_HOLD = 1, M_REDIR = 2;

  int          m_mode;
  logic        m_req;
  logic [31:0] m_pc;
  rec_t        m_out;
  rec_t        m_skid[$];
  int          m_bht[16];

`ifdef FETCH_BHT_EN
  localparam bit BHT_EN = 1'b1;
`else
  localparam bit BHT_EN = 1'b0;
`endif

  task automatic model_reset();
    m_mode = M_FETCH;
    m_req  = 1'b0;
    m_pc   = RST_PC;
    m_out  = '0;
    m_skid.delete();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    rec_t fetched;
    int   idx;
    int   cnt;
    fetched.instr = memword(m_pc);
    fetched.pc    = m_pc;
    fetched.pc4   = m_pc + 32'd4;
    fetched.preds = BHT_EN ? 2'(m_bht[m_pc[5:2]]) : 2'b01;
    fetched.valid = 1'b1;
    if (FLUSH) begin
      m_pc   = Redirect_Addr;
      m_out  = '0;
      m_skid.delete();
      m_mode = M_REDIR;
    end else if (m_mode == M_FETCH) begin
      if (m_req && Imem_Ack) begin
        if (!STALL || !m_out.valid) m_out = fetched;
        else begin
          m_skid.push_back(fetched);
          m_mode = M_HOLD;
        end
        m_pc = m_pc + 32'd4;
      end else if (!STALL) m_out = '0;
    end else if (m_mode == M_HOLD) begin
      if (!STALL) begin
        m_out  = m_skid.pop_front();
        m_mode = M_FETCH;
      end
    end else begin
      m_mode = M_FETCH;
      if (!STALL) m_out = '0;
    end
    m_req = (m_mode == M_FETCH);
    if (BHT_EN && BP_Update) begin
      idx = int'(BP_Update_PC[5:2]);
      cnt = m_bht[idx] + (BP_Update_Taken ? 1 : -1);
      m_bht[idx] = (cnt > 3) ? 3 : ((cnt < 0) ? 0 : cnt);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req",   32'(Imem_Req), 32'(m_req));
    chk("imem_addr",  Imem_Addr, m_pc);
    chk("instr",      Instr1_IF, m_out.instr);
    chk("instr_pc",   Instr_PC_IF, m_out.pc);
    chk("instr_pc4",  Instr_PC_Plus4_IF, m_out.pc4);
    chk("valid",      32'(Instr_Valid_IF), 32'(m_out.valid));
    chk("preds",      32'(Branch_predictions_IF), 32'(m_out.preds));
    chk("pred",       32'(Branch_prediction_IF), 32'(m_out.preds[1]));
  endtask

  // One clock: model and DUT both advance, then compare at the falling edge
  task automatic cyc();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock
  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    chk("rst_req",   32'(Imem_Req), 32'd0);
    chk("rst_addr",  Imem_Addr, RST_PC);
    chk("rst_instr", Instr1_IF, 32'd0);
    chk("rst_pc",    Instr_PC_IF, 32'd0);
    chk("rst_pc4",   Instr_PC_Plus4_IF, 32'd0);
    chk("rst_valid", 32'(Instr_Valid_IF), 32'd0);
    chk("rst_preds", 32'(Branch_predictions_IF), 32'd0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    do_reset();

    // Straight-line fetch from the reset vector
    Imem_Ack = 1'b1;
    STALL = 1'b0;
    cyc();
    chk("first_req", 32'(Imem_Req), 32'd1);
    chk("first_addr", Imem_Addr, 32'hBFC0_0000);
    cyc();
    chk("seq_addr1", Imem_Addr, 32'hBFC0_0004);
    chk("seq_out0", Instr_PC_IF, 32'hBFC0_0000);
    cyc();
    chk("seq_addr2", Imem_Addr, 32'hBFC0_0008);
    chk("seq_out1", Instr_PC_IF, 32'hBFC0_0004);
    cyc();

    // Stall for three cycles while acks keep arriving
    STALL = 1'b1;
    cyc();
    chk("hold_req", 32'(Imem_Req), 32'd0);
    chk("hold_frozen", Instr_PC_IF, 32'hBFC0_0008);
    cyc();
    cyc();
    STALL = 1'b0;
    cyc();
    chk("skid_out", Instr_PC_IF, 32'hBFC0_000C);
    cyc();
    chk("after_skid", Instr_PC_IF, 32'hBFC0_0010);

    // Flush concurrent with an ack
    FLUSH = 1'b1;
    Redirect_Addr = 32'h0040_0100;
    cyc();
    FLUSH = 1'b0;
    chk("flush_bubble", 32'(Instr_Valid_IF), 32'd0);
    chk("redir_req", 32'(Imem_Req), 32'd0);
    cyc();
    chk("redir_addr", Imem_Addr, 32'h0040_0100);
    cyc();
    chk("redir_out", Instr_PC_IF, 32'h0040_0100);

    // Address wrap at the top of memory
    FLUSH = 1'b1;
    Redirect_Addr = 32'hFFFF_FFFC;
    cyc();
    FLUSH = 1'b0;
    cyc();
    cyc();
    chk("wrap_pc4", Instr_PC_Plus4_IF, 32'd0);
    chk("wrap_addr", Imem_Addr, 32'd0);
    cyc();

    // Reset while in HOLD
    STALL = 1'b1;
    cyc();
    cyc();
    do_reset();
    STALL = 1'b0;
    cyc();
    chk("post_rst_addr", Imem_Addr, RST_PC);

    // Branch history training at 0x00400010
    Imem_Ack = 1'b0;
    BP_Update_PC = 32'h0040_0010;
    BP_Update_Taken = 1'b1;
    BP_Update = 1'b1;
    repeat (3) cyc();
    BP_Update = 1'b0;
    FLUSH = 1'b1;
    Redirect_Addr = 32'h0040_0010;
    cyc();
    FLUSH = 1'b0;
    Imem_Ack = 1'b1;
    cyc();
    cyc();
`ifdef FETCH_BHT_EN
    chk("bht_taken_preds", 32'(Branch_predictions_IF), 32'd3);
    chk("bht_taken_pred", 32'(Branch_prediction_IF), 32'd1);
`else
    chk("nobht_preds", 32'(Branch_predictions_IF), 32'd1);
    chk("nobht_pred", 32'(Branch_prediction_IF), 32'd0);
`endif
    Imem_Ack = 1'b0;
    BP_Update_Taken = 1'b0;
    BP_Update = 1'b1;
    repeat (4) cyc();
    BP_Update = 1'b0;
    FLUSH = 1'b1;
    cyc();
    FLUSH = 1'b0;
    Imem_Ack = 1'b1;
    cyc();
    cyc();
`ifdef FETCH_BHT_EN
    chk("bht_nt_preds", 32'(Branch_predictions_IF), 32'd0);
`else
    chk("nobht_preds2", 32'(Branch_predictions_IF), 32'd1);
`endif
    chk("bht_nt_pred", 32'(Branch_prediction_IF), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      STALL = ($urandom_range(0, 3) == 0);
      Imem_Ack = ($urandom_range(0, 3) != 0);
      FLUSH = ($urandom_range(0, 31) == 0);
      Redirect_Addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      BP_Update = ($urandom_range(0, 1) == 1);
      BP_Update_PC = $urandom();
      BP_Update_Taken = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
